// File: rtl/rcpa_accum.sv
// Sums N_SUMS {cout,s} adder results into an ACC_W accumulator with a sticky overflow flag; one result per cycle in ACC.
// Result is held with out_valid until out_ready; s_ready is low outside ACC. RCPA_ACCUM_SAT_EN selects saturate instead of wrap.
module rcpa_accum #(
  parameter int N_SUMS = 4,
  parameter int ACC_W  = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [15:0]      s,
  input  logic             cout,
  output logic [ACC_W-1:0] acc,
  output logic             ovf,
  output logic [7:0]       cnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [ACC_W:0]   sample;
  logic [ACC_W:0]   sum;
  logic [7:0]       cnt_nxt;
  logic             last;

  // One spare bit on the adder catches the carry out of ACC_W.
  assign sample  = {{(ACC_W-16){1'b0}}, cout, s};
  assign sum     = {1'b0, acc} + sample;
  assign cnt_nxt = cnt + 8'd1;
  assign last    = (cnt_nxt == 8'(N_SUMS));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            ovf   <= 1'b0;
            cnt   <= '0;
            state <= ACC;
          end
        end
        ACC: begin
          if (s_valid) begin
            cnt <= cnt_nxt;
            if (sum[ACC_W])
              ovf <= 1'b1;
`ifdef RCPA_ACCUM_SAT_EN
            if (ovf || sum[ACC_W])
              acc <= '1;
            else
              acc <= sum[ACC_W-1:0];
`else
            acc <= sum[ACC_W-1:0];
`endif
            if (last)
              state <= DONE;
          end
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign s_ready   = (state == ACC);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: doc/rcpa_accum.md
# rcpa_accum

Accumulation stage directly downstream of the 16-bit ripple-carry adder (`rcpa`). It consumes the adder's `{cout, s}` result through a valid/ready handshake and sums a programmed number of results into a wide accumulator. It presents the total with an overflow flag on an output handshake. Typical use is multi-word checksums and running totals built from successive `rcpa` additions.

## Interface
- `N_SUMS`, default 4: number of adder results per accumulation run; legal range 1..255.
- `ACC_W`, default 24: accumulator width; must be >= 17.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `s_valid`  in  1  `s`/`cout` carry a valid adder result.
- `s_ready`  out  1  stage accepts a result this cycle.
- `s`  in  16  adder sum.
- `cout`  in  1  adder carry-out.
- `acc`  out  ACC_W  accumulated total.
- `ovf`  out  1  sticky overflow for the current run.
- `cnt`  out  8  results accepted so far in this run.
- `out_valid`  out  1  `acc`/`ovf` final.
- `out_ready`  in  1  consumer takes the result.
- `busy`  out  1  high in ACC and DONE.

## Operation
- Sample value is `{cout, s}` (17 bits), zero-extended to `ACC_W`.
- A transfer occurs when `s_valid & s_ready` is high at a rising edge.
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - `s_ready=0`, `out_valid=0`.
  - If `start=1`: clear `acc`, `cnt` and `ovf`, then go to ACC.
- ACC:
  - `s_ready=1`.
  - Each transfer: `acc <= acc + sample`, `cnt <= cnt + 1`.
  - If the sum carries out of `ACC_W` bits, set `ovf=1`.
  - The transfer that makes `cnt == N_SUMS` moves the FSM to DONE.
  - No transfer means no change; `s_valid` gaps are allowed.
- DONE:
  - `s_ready=0`, `out_valid=1`.
  - `acc`, `ovf` and `cnt` are held stable.
  - On `out_ready=1`, go to IDLE. `acc`, `ovf` and `cnt` keep their values until the next `start`.
- `start` is ignored in ACC and DONE.
- Overflow without `SAT_EN`: `acc` wraps modulo 2^`ACC_W`.

## Timing
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.
- Reset values:
  - FSM in IDLE.
  - `acc=0`, `ovf=0`, `cnt=0`.
  - `s_ready=0`, `out_valid=0`, `busy=0`.
- `start` at edge T: `s_ready=1` from T+1.
- First accepted result is reflected in `acc` one cycle after its transfer edge.
- `out_valid` rises the cycle after the final transfer.
- Minimum run length is 1 + `N_SUMS` + 1 cycles (start, transfers, handshake).
- A `rst` asserted in any state, mid-run or with `out_valid` pending, takes priority over everything else. The next edge forces the reset values and discards the partial run.
- Simultaneous `start` and `out_ready` in DONE: return to IDLE only; the `start` is not latched.
- `cnt` never exceeds `N_SUMS`.

## Configuration
- `RCPA_ACCUM_SAT_EN`
  - Defined: on overflow `acc` saturates to all-ones and stays there for the rest of the run; `ovf` is set.
  - Undefined: `acc` wraps modulo 2^`ACC_W` and `ovf` is set. All other behaviour is identical.

## Test plan
- Normal run, `N_SUMS=3`, `ACC_W=24`.
  - Stimulus: `start`, then results (0x861F, cout 0), (0xECFD, cout 0), (0x7FC0, cout 1) on consecutive cycles.
  - Required: `out_valid=1` one cycle after the third transfer, `acc=0x02F2DC`, `ovf=0`, `cnt=3`.
- Stalls.
  - Stimulus: same data with `s_valid` low for 2 cycles between results.
  - Required: same `acc=0x02F2DC`; `cnt` increments only on transfers.
- Overflow, `ACC_W=17`, `N_SUMS=2`.
  - Stimulus: results 0x1FFFF then 0x00001.
  - Required without macro: `acc=0x00000`, `ovf=1`. With `RCPA_ACCUM_SAT_EN`: `acc=0x1FFFF`, `ovf=1`.
- Output backpressure.
  - Stimulus: `out_ready` held low 5 cycles in DONE, with `start` and `s_valid` pulsed during that time.
  - Required: `acc`/`cnt` unchanged, `s_ready=0`; IDLE is entered one cycle after `out_ready` rises.
- Reset mid-run.
  - Stimulus: `rst=1` after 2 of 4 transfers.
  - Required: next cycle `acc=0`, `cnt=0`, `busy=0`, `s_ready=0`. A following `start` run of 4×0x0001 gives `acc=4`.
